nios_system_nios2_cpu_div_cell: RTL
===================================

Name: nios_system_nios2_cpu_div_cell

Overview:
- Iterative radix-2 restoring divider. It is the inverse-operation companion to the CPU's pipelined 16x16 partial-product multiplier cell.
- Serves the Nios II div/divu instructions and returns either the quotient or the remainder.
- Operands come from the E stage. The result returns to the pipeline through a start/done handshake, with stall held via busy.
- Multi-cycle; no DSP blocks used.

Parameters:
- WIDTH, 32, operand and result width in bits (must be even, ≥ 4).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- E_src1  input  WIDTH  dividend; sampled only in the start cycle.
- E_src2  input  WIDTH  divisor; sampled only in the start cycle.
- E_div_signed  input  1  1 = two's-complement operands (div), 0 = unsigned (divu); sampled at start.
- E_div_rem  input  1  1 = return remainder, 0 = return quotient; sampled at start.
- E_div_start  input  1  single-cycle request; honoured only when busy=0.
- M_kill  input  1  pipeline flush; aborts any operation in progress.
- M_div_busy  output  1  high from the cycle after an accepted start until done.
- M_div_done  output  1  one-cycle pulse; result valid in the same cycle.
- M_div_result  output  WIDTH  quotient or remainder; held until the next accepted start.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, result=0, all internal registers=0. Reset mid-operation abandons it; no done follows.
- States: IDLE, CALC, FIX.
- IDLE:
  - On E_div_start=1 and M_kill=0, capture the operands and control bits.
  - Form magnitudes: |src| when signed and MSB=1, else the raw value. Record q_neg = signed & (s1[msb] ^ s2[msb]) and r_neg = signed & s1[msb].
  - Set divz = (src2==0), count=WIDTH, busy=1, go to CALC.
- CALC (WIDTH cycles):
  - Each cycle shift {rem,quo} left by 1 with the dividend MSB entering rem; trial = rem_shifted − divisor (WIDTH+1 bits).
  - If trial is non-negative, rem=trial and quotient LSB=1; otherwise keep rem and set quotient LSB=0.
  - Decrement count; at count==1 go to FIX.
- FIX (1 cycle):
  - Apply signs: quotient negated if q_neg; remainder negated if r_neg.
  - Select by E_div_rem and load M_div_result. Pulse done=1 on the next edge, clear busy, return to IDLE.
- Latency: done asserts exactly WIDTH+2 clock edges after the edge that sampled the start (34 for WIDTH=32).
- Divide by zero (divz): quotient forced to all-ones, remainder forced to the original E_src1, independent of signedness. Latency unchanged.
- Signed overflow (most negative / −1): quotient = 0x80000000, remainder = 0. This falls out of magnitude arithmetic; no special case is needed, but the bench must check it.
- E_div_start while busy=1: ignored; no state change.
- M_kill=1 in any state: next state IDLE, busy=0, no done pulse, M_div_result unchanged.
  - M_kill with E_div_start in the same cycle: kill wins, start is not accepted.
- done is never asserted in the same cycle as busy=1. The cycle after done, a new start is accepted.
- reset has priority over M_kill, which has priority over E_div_start.

Test Plan:
1. Unsigned basic: divu 100/7 with rem=0 -> done at edge 34, result=14. Repeat with rem=1 -> result=2. busy high for cycles 1..33.
2. Signed sign rules: div −7/2 -> quotient 0xFFFFFFFD (−3); remainder 0xFFFFFFFF (−1). Also 7/−2 -> −3 rem 1; −7/−2 -> 3 rem −1.
3. Boundaries:
   - div 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
   - divu 0xFFFFFFFF/1 -> 0xFFFFFFFF.
   - divu 5/9 -> quotient 0, remainder 5.
4. Divide by zero: divu 123/0 -> quotient 0xFFFFFFFF, remainder 123. div −5/0 -> quotient 0xFFFFFFFF, remainder 0xFFFFFFFB. Both at edge 34.
5. Handshake:
   - Start at edge 0 (100/7), second start at edge 10 (50/5) -> only 14 produced at edge 34.
   - Start 50/5 at edge 35 -> 10 at edge 69.
   - Back-to-back start the cycle after done is accepted.
6. Abort:
   - M_kill at edge 15 -> busy=0 at edge 16, no done, result keeps its prior value.
   - reset asserted at edge 20 of an operation -> all outputs 0 next edge.
   - Start+kill in the same cycle -> not accepted.

Source files
------------

// File: rtl/nios_system_nios2_cpu_div_cell.sv
// Iterative radix-2 restoring divider for the Nios II div/divu instructions.
// Returns the quotient or remainder through a start/busy/done handshake.
module nios_system_nios2_cpu_div_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] E_src1,
  input  logic [WIDTH-1:0] E_src2,
  input  logic             E_div_signed,
  input  logic             E_div_rem,
  input  logic             E_div_start,
  input  logic             M_kill,
  output logic             M_div_busy,
  output logic             M_div_done,
  output logic [WIDTH-1:0] M_div_result
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_q,     state_d;
  logic [CW-1:0]    count_q,     count_d;
  logic [WIDTH-1:0] rem_q,       rem_d;
  logic [WIDTH-1:0] quo_q,       quo_d;
  logic [WIDTH-1:0] div_q,       div_d;
  logic [WIDTH-1:0] src1_q,      src1_d;
  logic             q_neg_q,     q_neg_d;
  logic             r_neg_q,     r_neg_d;
  logic             divz_q,      divz_d;
  logic             rem_sel_q,   rem_sel_d;
  logic             fin_q,       fin_d;
  logic [WIDTH-1:0] stage_q,     stage_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic [WIDTH-1:0] result_q,    result_d;

  logic             accept;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // Operand conditioning and one restoring step, shared by the FSM below.
  always_comb begin
    accept  = (state_q == IDLE) && !busy_q && E_div_start && !M_kill;
    mag1    = (E_div_signed && E_src1[WIDTH-1]) ? -E_src1 : E_src1;
    mag2    = (E_div_signed && E_src2[WIDTH-1]) ? -E_src2 : E_src2;
    rem_sh  = {rem_q, quo_q[WIDTH-1]};
    trial   = rem_sh - {1'b0, div_q};
    quo_fix = q_neg_q ? -quo_q : quo_q;
    rem_fix = r_neg_q ? -rem_q : rem_q;
    if (divz_q) begin
      quo_fix = '1;
      rem_fix = src1_q;
    end
  end

  // NOTE: every variable gets its hold/default value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    src1_d    = src1_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    divz_d    = divz_q;
    rem_sel_d = rem_sel_q;
    fin_d     = 1'b0;
    stage_d   = stage_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;

    if (M_kill) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else begin
      // Result is published one edge after FIX so done and result appear together.
      if (fin_q) begin
        done_d   = 1'b1;
        busy_d   = 1'b0;
        result_d = stage_q;
      end

      unique case (state_q)
        IDLE: begin
          if (accept) begin
            rem_d     = '0;
            quo_d     = mag1;
            div_d     = mag2;
            src1_d    = E_src1;
            q_neg_d   = E_div_signed & (E_src1[WIDTH-1] ^ E_src2[WIDTH-1]);
            r_neg_d   = E_div_signed & E_src1[WIDTH-1];
            divz_d    = (E_src2 == '0);
            rem_sel_d = E_div_rem;
            count_d   = CW'(WIDTH);
            busy_d    = 1'b1;
            state_d   = CALC;
          end
        end
        CALC: begin
          if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          count_d = count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_d = FIX;
          end
        end
        FIX: begin
          stage_d = rem_sel_q ? rem_fix : quo_fix;
          fin_d   = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are cleared too, since reset must leave every register at zero.
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      src1_q    <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      divz_q    <= 1'b0;
      rem_sel_q <= 1'b0;
      fin_q     <= 1'b0;
      stage_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      src1_q    <= src1_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      divz_q    <= divz_d;
      rem_sel_q <= rem_sel_d;
      fin_q     <= fin_d;
      stage_q   <= stage_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign M_div_busy   = busy_q;
  assign M_div_done   = done_q;
  assign M_div_result = result_q;

endmodule
